// File: rtl/button_scan_pkg.sv
// Shared types and defaults for the button shift-register scanner.
package button_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        SHIFT,
        DONE
    } scan_state_t;

    localparam int unsigned DEF_CLK_DIV        = 25;
    localparam int unsigned DEF_NUM_BITS       = 16;
    localparam int unsigned DEF_SCAN_GAP       = 1000;
    localparam int unsigned DEF_DEBOUNCE_SCANS = 4;
    localparam bit          DEF_ACTIVE_LOW     = 1'b1;

    // Width of each per-button debounce counter.
    localparam int unsigned DEB_CNT_W = 4;

endpackage

// File: rtl/button_debounce.sv
// Vector-wide debouncer: a bit's stable state flips only after
// DEBOUNCE_SCANS consecutive scans that disagree with it.
module button_debounce
    import button_scan_pkg::*;
#(
    parameter int unsigned NUM_BITS       = DEF_NUM_BITS,
    parameter int unsigned DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_BITS-1:0] raw,
    input  logic                update,
    output logic [NUM_BITS-1:0] stable,
    output logic [NUM_BITS-1:0] pressed,
    output logic [NUM_BITS-1:0] released
);

    logic [DEB_CNT_W-1:0] cnt      [NUM_BITS];
    logic [DEB_CNT_W-1:0] cnt_next [NUM_BITS];
    logic [NUM_BITS-1:0]  stable_next;
    logic                 commit;

    // Per-bit debounce rule applied to the current raw scan.
    always_comb begin
        stable_next = stable;
        for (int unsigned i = 0; i < NUM_BITS; i++) begin
            cnt_next[i] = cnt[i] + 1'b1;
            if (raw[i] == stable[i]) begin
                cnt_next[i] = '0;
            end else if ((cnt[i] + 1'b1) == DEB_CNT_W'(DEBOUNCE_SCANS)) begin
                stable_next[i] = raw[i];
                cnt_next[i]    = '0;
            end
        end
    end

    // Event masks are registered on the strobe so they line up with the
    // DONE cycle; stable/counters commit one cycle later so the button
    // vector changes after DONE. raw cannot change in between (sampling
    // happens only while shifting), so both see the same next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            commit   <= 1'b0;
            stable   <= '0;
            pressed  <= '0;
            released <= '0;
            cnt      <= '{default: '0};
        end else begin
            commit   <= update;
            pressed  <= update ? (stable_next & ~stable) : '0;
            released <= update ? (~stable_next & stable) : '0;
            if (commit) begin
                stable <= stable_next;
                cnt    <= cnt_next;
            end
        end
    end

endmodule

// File: rtl/button_scan_ctrl.sv
// Scan sequencer for the 165-style button shift register: load, settle,
// shift the bits in MSB first, then hand the scan to the debouncer.
module button_scan_ctrl
    import button_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV        = DEF_CLK_DIV,
    parameter int unsigned NUM_BITS       = DEF_NUM_BITS,
    parameter int unsigned SCAN_GAP       = DEF_SCAN_GAP,
    parameter int unsigned DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
    parameter bit          ACTIVE_LOW     = DEF_ACTIVE_LOW
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                shift_out,
    output logic                shift_load_n,
    output logic                shift_clk,
    output logic [NUM_BITS-1:0] buttons,
    output logic [NUM_BITS-1:0] pressed,
    output logic [NUM_BITS-1:0] released,
    output logic                scan_done
);

    localparam int unsigned CNT_MAX = (SCAN_GAP > CLK_DIV) ? SCAN_GAP : CLK_DIV;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    scan_state_t         state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                phase, phase_next;   // 0 = low half, 1 = high half
    logic [BIT_W-1:0]    bit_idx, bit_next;
    logic                sample;
    logic [1:0]          sync;
    logic [NUM_BITS-1:0] raw_sr;

    // Two-flop synchronizer for the asynchronous serial input.
    always_ff @(posedge clock) begin
        if (reset) sync <= '0;
        else       sync <= {sync[0], shift_out};
    end

    // FSM state, shared down-counter, and shift phase/bit counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= CNT_W'(SCAN_GAP);
            phase   <= 1'b0;
            bit_idx <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            phase   <= phase_next;
            bit_idx <= bit_next;
        end
    end

    // Next-state logic; each state ends when the down-counter reaches 1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt - 1'b1;
        phase_next = phase;
        bit_next   = bit_idx;
        sample     = 1'b0;
        unique case (state)
            IDLE: if (cnt == CNT_W'(1)) begin
                state_next = LOAD;
                cnt_next   = CNT_W'(CLK_DIV);
            end
            LOAD: if (cnt == CNT_W'(1)) begin
                state_next = SETTLE;
                cnt_next   = CNT_W'(CLK_DIV);
            end
            SETTLE: if (cnt == CNT_W'(1)) begin
                state_next = SHIFT;
                cnt_next   = CNT_W'(CLK_DIV);
                phase_next = 1'b0;
                bit_next   = '0;
            end
            SHIFT: if (cnt == CNT_W'(1)) begin
                cnt_next = CNT_W'(CLK_DIV);
                if (!phase) begin
                    sample     = 1'b1;
                    phase_next = 1'b1;
                end else if (bit_idx == BIT_W'(NUM_BITS - 1)) begin
                    state_next = DONE;
                    phase_next = 1'b0;
                end else begin
                    phase_next = 1'b0;
                    bit_next   = bit_idx + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = CNT_W'(SCAN_GAP);
            end
            default: begin
                state_next = IDLE;
                cnt_next   = CNT_W'(SCAN_GAP);
            end
        endcase
    end

    // Pin and strobe outputs are registered from the next state so they
    // coincide exactly with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_load_n <= 1'b1;
            shift_clk    <= 1'b0;
            scan_done    <= 1'b0;
        end else begin
            shift_load_n <= (state_next != LOAD);
            shift_clk    <= (state_next == SHIFT) && phase_next;
            scan_done    <= (state_next == DONE);
        end
    end

    // Serial-in shift register; first sampled bit ends up in the MSB.
    always_ff @(posedge clock) begin
        if (reset)       raw_sr <= '0;
        else if (sample) raw_sr <= {raw_sr[NUM_BITS-2:0], sync[1] ^ ACTIVE_LOW};
    end

    button_debounce #(
        .NUM_BITS       (NUM_BITS),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clock    (clock),
        .reset    (reset),
        .raw      (raw_sr),
        .update   (state_next == DONE),
        .stable   (buttons),
        .pressed  (pressed),
        .released (released)
    );

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Self-checking bench: two scanners (debounce depth 2 and 1) read
// behavioural 165-style registers; a scan-level reference model predicts
// the debounced state and event masks.
module tb_button_scan_ctrl;

    localparam int CD  = 4;
    localparam int NB  = 16;
    localparam int GAP = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic          so_a, so_b;
    logic          ln_a, ln_b, sc_a, sc_b, sd_a, sd_b;
    logic [NB-1:0] btn_a, prs_a, rel_a, btn_b, prs_b, rel_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clock = ~clock;

    button_scan_ctrl #(
        .CLK_DIV(CD), .NUM_BITS(NB), .SCAN_GAP(GAP), .DEBOUNCE_SCANS(2), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clock(clock), .reset(reset), .shift_out(so_a), .shift_load_n(ln_a),
        .shift_clk(sc_a), .buttons(btn_a), .pressed(prs_a), .released(rel_a),
        .scan_done(sd_a)
    );

    button_scan_ctrl #(
        .CLK_DIV(CD), .NUM_BITS(NB), .SCAN_GAP(GAP), .DEBOUNCE_SCANS(1), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clock(clock), .reset(reset), .shift_out(so_b), .shift_load_n(ln_b),
        .shift_clk(sc_b), .buttons(btn_b), .pressed(prs_b), .released(rel_b),
        .scan_done(sd_b)
    );

    // Behavioural 165 registers: parallel load while load is low,
    // shift towards the serial output on each rising shift clock.
    logic [NB-1:0] wire_pat [2];
    logic [NB-1:0] sreg     [2] = '{16'h0, 16'h0};
    logic          prev_sc  [2] = '{1'b0, 1'b0};

    always @(negedge clock) begin
        if (!ln_a)                     sreg[0] = wire_pat[0];
        else if (sc_a && !prev_sc[0])  sreg[0] = sreg[0] << 1;
        prev_sc[0] = sc_a;
        if (!ln_b)                     sreg[1] = wire_pat[1];
        else if (sc_b && !prev_sc[1])  sreg[1] = sreg[1] << 1;
        prev_sc[1] = sc_b;
    end

    assign so_a = sreg[0][NB-1];
    assign so_b = sreg[1][NB-1];

    // Scan-level reference model.
    logic [NB-1:0] ref_stable [2];
    int            ref_cnt    [2][NB];
    int            ds_of      [2] = '{2, 1};

    task automatic ref_reset();
        for (int k = 0; k < 2; k++) begin
            ref_stable[k] = '0;
            for (int i = 0; i < NB; i++) ref_cnt[k][i] = 0;
        end
    endtask

    task automatic ref_scan(input int k, output logic [NB-1:0] p, output logic [NB-1:0] r);
        logic [NB-1:0] pressed_level;
        logic [NB-1:0] nxt;
        pressed_level = ~wire_pat[k];
        nxt = ref_stable[k];
        for (int i = 0; i < NB; i++) begin
            if (pressed_level[i] == ref_stable[k][i]) begin
                ref_cnt[k][i] = 0;
            end else if (ref_cnt[k][i] + 1 == ds_of[k]) begin
                nxt[i] = pressed_level[i];
                ref_cnt[k][i] = 0;
            end else begin
                ref_cnt[k][i] = ref_cnt[k][i] + 1;
            end
        end
        p = nxt & ~ref_stable[k];
        r = ~nxt & ref_stable[k];
        ref_stable[k] = nxt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Results of the most recent scan observation.
    int            r_lf, r_ll, r_nrise, r_sd;
    bit            r_space_ok, r_stray, r_sdb;
    logic [NB-1:0] r_pa, r_ra, r_pb, r_rb, r_ba_sd, r_bb_sd, r_ba, r_bb;

    task automatic run_scan();
        int start;
        int last_rise;
        int exp_rise;
        logic prev;
        start = cyc; last_rise = -1; prev = sc_a;
        r_lf = -1; r_ll = 0; r_nrise = 0; r_sd = -1;
        r_space_ok = 1'b1; r_stray = 1'b0; r_sdb = 1'b0;
        while (r_sd < 0 && cyc - start < 400) begin
            tick();
            if (!ln_a) begin
                if (r_lf < 0) r_lf = cyc;
                r_ll++;
            end
            if (sc_a && !prev) begin
                r_nrise++;
                exp_rise = (last_rise < 0) ? r_lf + 2 * CD + CD : last_rise + 2 * CD;
                if (cyc != exp_rise) r_space_ok = 1'b0;
                last_rise = cyc;
            end
            prev = sc_a;
            if (sd_a) begin
                r_sd = cyc; r_sdb = sd_b;
                r_pa = prs_a; r_ra = rel_a; r_pb = prs_b; r_rb = rel_b;
                r_ba_sd = btn_a; r_bb_sd = btn_b;
            end else if (|{prs_a, rel_a, prs_b, rel_b}) begin
                r_stray = 1'b1;
            end
        end
        if (r_sd >= 0) begin
            tick();
            r_ba = btn_a; r_bb = btn_b;
            if (|{prs_a, rel_a, prs_b, rel_b, sd_a}) r_stray = 1'b1;
        end
    endtask

    task automatic do_scan(input string tag);
        logic [NB-1:0] ea_p, ea_r, eb_p, eb_r, olda, oldb;
        olda = ref_stable[0];
        oldb = ref_stable[1];
        run_scan();
        ref_scan(0, ea_p, ea_r);
        ref_scan(1, eb_p, eb_r);
        chk({tag, ".completed"}, 32'(r_sd >= 0), 32'd1);
        chk({tag, ".done_b_aligned"}, 32'(r_sdb), 32'd1);
        chk({tag, ".load_to_done"}, r_sd - r_lf, 2 * CD + 2 * CD * NB);
        chk({tag, ".load_len"}, r_ll, CD);
        chk({tag, ".clk_rises"}, r_nrise, NB);
        chk({tag, ".clk_spacing"}, 32'(r_space_ok), 32'd1);
        chk({tag, ".stray_events"}, 32'(r_stray), 32'd0);
        chk({tag, ".pressed_a"}, 32'(r_pa), 32'(ea_p));
        chk({tag, ".released_a"}, 32'(r_ra), 32'(ea_r));
        chk({tag, ".pressed_b"}, 32'(r_pb), 32'(eb_p));
        chk({tag, ".released_b"}, 32'(r_rb), 32'(eb_r));
        chk({tag, ".buttons_a_at_done"}, 32'(r_ba_sd), 32'(olda));
        chk({tag, ".buttons_b_at_done"}, 32'(r_bb_sd), 32'(oldb));
        chk({tag, ".buttons_a"}, 32'(r_ba), 32'(ref_stable[0]));
        chk({tag, ".buttons_b"}, 32'(r_bb), 32'(ref_stable[1]));
    endtask

    initial begin
        int lf1;
        int r0;
        int target;
        wire_pat[0] = 16'h00FF;
        wire_pat[1] = 16'hFFFE;
        ref_reset();

        // Reset state.
        repeat (3) tick();
        chk("rst.load_n", 32'(ln_a), 32'd1);
        chk("rst.shift_clk", 32'(sc_a), 32'd0);
        chk("rst.buttons", 32'(btn_a), 32'd0);
        chk("rst.events", 32'({prs_a, rel_a, sd_a}), 32'd0);

        reset = 1'b0;
        cyc = 0;

        // First scan: load at cycle GAP, done at GAP+8+128.
        do_scan("scan1");
        chk("first.load_cycle", r_lf, GAP);
        chk("first.done_cycle", r_sd, 144);
        chk("first.buttons_a", 32'(r_ba), 32'h0);
        chk("first.ds1_pressed", 32'(r_pb), 32'h0001);
        chk("first.ds1_buttons", 32'(r_bb), 32'h0001);
        lf1 = r_lf;

        do_scan("scan2");
        chk("period", r_lf - lf1, 145);
        chk("press.pressed", 32'(r_pa), 32'hFF00);
        chk("press.buttons", 32'(r_ba), 32'hFF00);

        wire_pat[0] = 16'hFFFF;
        do_scan("rel1");
        chk("release.early", 32'(r_ra), 32'h0);
        do_scan("rel2");
        chk("release.released", 32'(r_ra), 32'hFF00);
        chk("release.buttons", 32'(r_ba), 32'h0);

        // Bit 3 bounces every scan and must never register.
        for (int i = 0; i < 6; i++) begin
            wire_pat[0] = (i % 2 == 0) ? 16'hFFF7 : 16'hFFFF;
            do_scan("bounce");
            chk("bounce.btn3", 32'(r_ba[3]), 32'd0);
            chk("bounce.press3", 32'(r_pa[3]), 32'd0);
        end

        // Random patterns, frequently held so debounce flips occur.
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 2) == 0) wire_pat[0] = 16'($urandom);
            if ($urandom_range(0, 2) == 0) wire_pat[1] = 16'($urandom);
            do_scan("random");
        end

        // Everything pressed so the reset check below is meaningful.
        wire_pat[0] = 16'h0000;
        wire_pat[1] = 16'h0000;
        do_scan("allon1");
        do_scan("allon2");
        chk("allon.buttons", 32'(btn_a), 32'hFFFF);

        // Reset in the middle of bit 7's high phase.
        r0 = cyc;
        while (ln_a && cyc - r0 < 300) tick();
        chk("midrst.found_load", 32'(ln_a), 32'd0);
        target = cyc + 2 * CD + 7 * 2 * CD + CD + 1;
        while (cyc < target) tick();
        chk("midrst.in_high_phase", 32'(sc_a), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst.shift_clk", 32'(sc_a), 32'd0);
        chk("midrst.load_n", 32'(ln_a), 32'd1);
        chk("midrst.buttons", 32'(btn_a), 32'd0);
        tick();
        chk("midrst.held_buttons_b", 32'(btn_b), 32'd0);
        reset = 1'b0;
        r0 = cyc;
        ref_reset();
        do_scan("after_rst");
        chk("midrst.next_load", r_lf - r0, GAP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
